halut_encoder_ctrl: RTL and testbench

HALUT_ENCODER_CTRL -- requirements
Module: halut_encoder_ctrl

---
 rtl/halut_pkg.sv | 32 +++
 rtl/halut_thresh_loader.sv | 93 +++++++++
 rtl/halut_encoder_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_halut_encoder_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/halut_pkg.sv
// -----------------------------------------------------------------------------
// halut_pkg
// Shared types and width helpers for the HALUT encoder controller.
//   halut_state_e     : controller state encoding (IDLE, LOAD, RUN, DONE)
//   ROWS_WIDTH        : width of the row count / row counter
//   clog2_min1()      : $clog2 clamped to at least 1 bit
//   thresh_addr_width : threshold memory address width per encoder unit
// -----------------------------------------------------------------------------
package halut_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } halut_state_e;

   localparam int unsigned ROWS_WIDTH = 16;

   // Counters still need one bit when the range collapses to a single value.
   function automatic int unsigned clog2_min1(input int unsigned value);
      return (value <= 32'd1) ? 32'd1 : $clog2(value);
   endfunction

   // Each unit holds (C/EncUnits) codebooks of K thresholds.
   function automatic int unsigned thresh_addr_width(input int unsigned c,
                                                     input int unsigned enc_units,
                                                     input int unsigned k);
      return clog2_min1((c / enc_units) * k);
   endfunction

endpackage

// File: rtl/halut_thresh_loader.sv
// -----------------------------------------------------------------------------
// halut_thresh_loader
// Turns the accepted threshold word stream into per-unit memory writes.
// Word i goes to unit i/Depth at address i mod Depth; the write is presented
// on the cycle after the handshake.
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : restart addressing at word 0 (start of a load)
//   hs_i          : a threshold word is accepted this cycle
//   data_i        : accepted threshold word
//   waddr_o       : per-unit write address (AddrWidth x EncUnits)
//   wdata_o       : per-unit write data (DataTypeWidth x EncUnits)
//   we_o          : per-unit write enable, one-hot or zero
//   last_o        : the next accepted word is the final one
// -----------------------------------------------------------------------------
module halut_thresh_loader
   import halut_pkg::*;
#(
   parameter int unsigned Depth         = 128,
   parameter int unsigned EncUnits      = 4,
   parameter int unsigned AddrWidth     = 7,
   parameter int unsigned DataTypeWidth = 16
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              clear_i,
   input  logic                              hs_i,
   input  logic [DataTypeWidth-1:0]          data_i,
   output logic [AddrWidth*EncUnits-1:0]     waddr_o,
   output logic [DataTypeWidth*EncUnits-1:0] wdata_o,
   output logic [EncUnits-1:0]               we_o,
   output logic                              last_o
);

   localparam int unsigned UnitWidth = clog2_min1(EncUnits);

   logic [AddrWidth-1:0]     addr_cnt_r;
   logic [UnitWidth-1:0]     unit_cnt_r;
   logic [AddrWidth-1:0]     waddr_r;
   logic [DataTypeWidth-1:0] wdata_r;
   logic [EncUnits-1:0]      we_r;
   logic                     addr_wrap_s;

   // Address/unit pair replaces a division of the flat word index.
   assign addr_wrap_s = (addr_cnt_r == AddrWidth'(Depth - 1));
   assign last_o      = addr_wrap_s && (unit_cnt_r == UnitWidth'(EncUnits - 1));

   // Word position counters: advance only on an accepted word.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_cnt_r <= '0;
         unit_cnt_r <= '0;
      end else if (clear_i) begin
         addr_cnt_r <= '0;
         unit_cnt_r <= '0;
      end else if (hs_i) begin
         if (last_o) begin
            addr_cnt_r <= '0;
            unit_cnt_r <= '0;
         end else if (addr_wrap_s) begin
            addr_cnt_r <= '0;
            unit_cnt_r <= unit_cnt_r + UnitWidth'(1);
         end else begin
            addr_cnt_r <= addr_cnt_r + AddrWidth'(1);
         end
      end else begin
         addr_cnt_r <= addr_cnt_r;
         unit_cnt_r <= unit_cnt_r;
      end
   end

   // Write port register: enable lives exactly one cycle per accepted word.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         waddr_r <= '0;
         wdata_r <= '0;
         we_r    <= '0;
      end else if (hs_i) begin
         waddr_r <= addr_cnt_r;
         wdata_r <= data_i;
         we_r    <= EncUnits'(1) << unit_cnt_r;
      end else begin
         waddr_r <= waddr_r;
         wdata_r <= wdata_r;
         we_r    <= '0;
      end
   end

   // Address and data are shared; only the enable selects the unit.
   assign waddr_o = {EncUnits{waddr_r}};
   assign wdata_o = {EncUnits{wdata_r}};
   assign we_o    = we_r;

endmodule

// File: rtl/halut_encoder_ctrl.sv
// -----------------------------------------------------------------------------
// halut_encoder_ctrl
// Controller for HALUT encoder units: loads C*K thresholds into EncUnits
// threshold memories, then runs the encoders for a requested number of rows.
//   clk_i, rst_ni          : clock, async active-low reset
//   load_start_i           : begin a threshold load
//   thr_valid_i/thr_data_i : threshold stream in, thr_ready_o back-pressure
//   waddr_o/wdata_o/we_o   : per-unit threshold memory write ports
//   start_i, rows_i        : start an encode of rows_i rows
//   abort_i                : abandon current load or run
//   encoder_o, enc_valid_i : encoder enable, encoder result valid
//   loaded_o, busy_o, done_o, row_cnt_o : status
// -----------------------------------------------------------------------------
module halut_encoder_ctrl
   import halut_pkg::*;
#(
   parameter int unsigned K             = 16,
   parameter int unsigned C             = 32,
   parameter int unsigned DataTypeWidth = 16,
   parameter int unsigned EncUnits      = 4
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  load_start_i,
   input  logic                                  thr_valid_i,
   input  logic [DataTypeWidth-1:0]              thr_data_i,
   output logic                                  thr_ready_o,
   output logic [thresh_addr_width(C, EncUnits, K)*EncUnits-1:0] waddr_o,
   output logic [DataTypeWidth*EncUnits-1:0]     wdata_o,
   output logic [EncUnits-1:0]                   we_o,
   input  logic                                  start_i,
   input  logic [ROWS_WIDTH-1:0]                 rows_i,
   input  logic                                  abort_i,
   output logic                                  encoder_o,
   input  logic                                  enc_valid_i,
   output logic                                  loaded_o,
   output logic                                  busy_o,
   output logic                                  done_o,
   output logic [ROWS_WIDTH-1:0]                 row_cnt_o
);

   localparam int unsigned Depth              = (C / EncUnits) * K;
   localparam int unsigned ThreshMemAddrWidth = thresh_addr_width(C, EncUnits, K);
   localparam int unsigned RowsWidth          = ROWS_WIDTH;
   localparam int unsigned CbWidth            = clog2_min1(C);

   halut_state_e           state_r;
   halut_state_e           state_next;
   logic                   loaded_r;
   logic [RowsWidth-1:0]   rows_r;
   logic [RowsWidth-1:0]   row_cnt_r;
   logic [CbWidth-1:0]     cb_cnt_r;
   logic                   busy_r;
   logic                   done_r;
   logic                   encoder_r;
   logic                   ready_r;

   logic                   in_idle_s;
   logic                   load_go_s;
   logic                   run_go_s;
   logic                   hs_s;
   logic                   enc_step_s;
   logic                   cb_wrap_s;
   logic                   rows_hit_s;
   logic                   last_word_s;

   // Abort outranks every other input, including requests made in IDLE.
   assign in_idle_s  = (state_r == ST_IDLE) && !abort_i;
   assign load_go_s  = in_idle_s && load_start_i;
   assign run_go_s   = in_idle_s && !load_start_i && start_i && loaded_r;
   assign hs_s       = (state_r == ST_LOAD) && thr_valid_i && !abort_i;
   assign enc_step_s = (state_r == ST_RUN) && enc_valid_i && !abort_i;
   assign cb_wrap_s  = (cb_cnt_r == CbWidth'(C - 1));
   assign rows_hit_s = ((row_cnt_r + RowsWidth'(1)) == rows_r);

   halut_thresh_loader #(
      .Depth         (Depth),
      .EncUnits      (EncUnits),
      .AddrWidth     (ThreshMemAddrWidth),
      .DataTypeWidth (DataTypeWidth)
   ) u_loader (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (load_go_s),
      .hs_i    (hs_s),
      .data_i  (thr_data_i),
      .waddr_o (waddr_o),
      .wdata_o (wdata_o),
      .we_o    (we_o),
      .last_o  (last_word_s)
   );

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next;
      end
   end

   // Next-state decode.
   always_comb begin
      state_next = state_r;
      case (state_r)
         ST_IDLE: begin
            if (load_go_s) begin
               state_next = ST_LOAD;
            end else if (run_go_s) begin
               state_next = (rows_i == RowsWidth'(0)) ? ST_DONE : ST_RUN;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (abort_i) begin
               state_next = ST_IDLE;
            end else if (hs_s && last_word_s) begin
               state_next = ST_IDLE;
            end else begin
               state_next = ST_LOAD;
            end
         end
         ST_RUN: begin
            if (abort_i) begin
               state_next = ST_IDLE;
            end else if (enc_step_s && cb_wrap_s && rows_hit_s) begin
               state_next = ST_DONE;
            end else begin
               state_next = ST_RUN;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Loaded flag: dropped when a load begins, set only by its final word.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         loaded_r <= 1'b0;
      end else if (load_go_s) begin
         loaded_r <= 1'b0;
      end else if (hs_s && last_word_s) begin
         loaded_r <= 1'b1;
      end else begin
         loaded_r <= loaded_r;
      end
   end

   // Row bookkeeping: codebook counter wraps into the row counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rows_r    <= '0;
         row_cnt_r <= '0;
         cb_cnt_r  <= '0;
      end else if (run_go_s) begin
         rows_r    <= rows_i;
         row_cnt_r <= '0;
         cb_cnt_r  <= '0;
      end else if (enc_step_s) begin
         rows_r    <= rows_r;
         row_cnt_r <= cb_wrap_s ? (row_cnt_r + RowsWidth'(1)) : row_cnt_r;
         cb_cnt_r  <= cb_wrap_s ? CbWidth'(0) : (cb_cnt_r + CbWidth'(1));
      end else begin
         rows_r    <= rows_r;
         row_cnt_r <= row_cnt_r;
         cb_cnt_r  <= cb_cnt_r;
      end
   end

   // Status outputs registered from the next state so they track the state exactly.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         encoder_r <= 1'b0;
         ready_r   <= 1'b0;
      end else begin
         busy_r    <= (state_next == ST_LOAD) || (state_next == ST_RUN);
         done_r    <= (state_next == ST_DONE);
         encoder_r <= (state_next == ST_RUN);
         ready_r   <= (state_next == ST_LOAD);
      end
   end

   assign thr_ready_o = ready_r;
   assign encoder_o   = encoder_r;
   assign busy_o      = busy_r;
   assign done_o      = done_r;
   assign loaded_o    = loaded_r;
   assign row_cnt_o   = row_cnt_r;

endmodule

// File: tb/tb_halut_encoder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_halut_encoder_ctrl
// Directed sequence with randomized data/valid patterns. Expected memory
// contents come from word index arithmetic (unit = i / depth, addr = i % depth);
// expected run progress comes from counting accepted encoder results
// (rows done = results / C, finished at rows * C results).
// -----------------------------------------------------------------------------
module tb_halut_encoder_ctrl;

   localparam int K     = 16;
   localparam int C     = 32;
   localparam int DW    = 16;
   localparam int EU    = 4;
   localparam int DEPTH = (C / EU) * K;
   localparam int AW    = $clog2(DEPTH);
   localparam int NW    = C * K;
   localparam int RW    = 16;

   logic              clk = 1'b0;
   logic              rst_ni;
   logic              load_start_i;
   logic              thr_valid_i;
   logic [DW-1:0]     thr_data_i;
   logic              thr_ready_o;
   logic [AW*EU-1:0]  waddr_o;
   logic [DW*EU-1:0]  wdata_o;
   logic [EU-1:0]     we_o;
   logic              start_i;
   logic [RW-1:0]     rows_i;
   logic              abort_i;
   logic              encoder_o;
   logic              enc_valid_i;
   logic              loaded_o;
   logic              busy_o;
   logic              done_o;
   logic [RW-1:0]     row_cnt_o;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] exp_mem [EU][DEPTH];
   logic [DW-1:0] dut_mem [EU][DEPTH];
   int nwrites;
   int spurious;

   always #5 clk = ~clk;

   halut_encoder_ctrl #(.K(K), .C(C), .DataTypeWidth(DW), .EncUnits(EU)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .load_start_i (load_start_i),
      .thr_valid_i  (thr_valid_i),
      .thr_data_i   (thr_data_i),
      .thr_ready_o  (thr_ready_o),
      .waddr_o      (waddr_o),
      .wdata_o      (wdata_o),
      .we_o         (we_o),
      .start_i      (start_i),
      .rows_i       (rows_i),
      .abort_i      (abort_i),
      .encoder_o    (encoder_o),
      .enc_valid_i  (enc_valid_i),
      .loaded_o     (loaded_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .row_cnt_o    (row_cnt_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are read 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_dut_mem();
      for (int u = 0; u < EU; u++)
         for (int a = 0; a < DEPTH; a++)
            dut_mem[u][a] = 'x;
   endtask

   // Record what the write ports show this cycle; hs says a write is due.
   task automatic capture(input bit hs);
      for (int u = 0; u < EU; u++) begin
         if (we_o[u]) begin
            dut_mem[u][waddr_o[u*AW +: AW]] = wdata_o[u*DW +: DW];
            nwrites++;
         end
      end
      if ((we_o != '0) != hs) spurious++;
      if ($countones(we_o) > 1) spurious++;
   endtask

   task automatic do_load(input int nhs, input bit rnd, input bit gaps);
      int i;
      int cyc;
      bit v;
      bit rdy;
      bit hs;
      logic [DW-1:0] d;
      nwrites  = 0;
      spurious = 0;
      load_start_i = 1'b1;
      tick();
      load_start_i = 1'b0;
      i   = 0;
      cyc = 0;
      while (i < nhs && cyc < 4 * NW) begin
         v = gaps ? (cyc % 2 == 0) : 1'b1;
         d = rnd ? DW'($urandom) : DW'(i);
         thr_valid_i = v;
         thr_data_i  = d;
         rdy = thr_ready_o;
         tick();
         cyc++;
         hs = v && rdy;
         if (hs) begin
            exp_mem[i / DEPTH][i % DEPTH] = d;
            i++;
         end
         capture(hs);
      end
      thr_valid_i = 1'b0;
      chk("load_words_accepted", i, nhs);
   endtask

   function automatic int mem_diffs();
      int n = 0;
      for (int u = 0; u < EU; u++)
         for (int a = 0; a < DEPTH; a++)
            if (dut_mem[u][a] !== exp_mem[u][a]) n++;
      return n;
   endfunction

   task automatic do_run(input int rows, input int pct,
                         output int enc_cyc, output int dones, output int terr);
      int nv;
      int cyc;
      bit v;
      bit in_run;
      bit fin;
      enc_cyc = 0; dones = 0; terr = 0; nv = 0; cyc = 0; fin = 0;
      start_i = 1'b1;
      rows_i  = RW'(rows);
      tick();
      start_i = 1'b0;
      while (!fin && cyc < 5000) begin
         v = ($urandom_range(99) < pct);
         enc_valid_i = v;
         in_run = encoder_o;
         tick();
         cyc++;
         if (in_run) enc_cyc++;
         if (done_o) dones++;
         if (in_run && v) nv++;
         if (nv == rows * C) begin
            fin = 1'b1;
            if (encoder_o !== 1'b0 || done_o !== 1'b1 || row_cnt_o !== RW'(rows)) terr++;
         end else if (encoder_o !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0 ||
                      row_cnt_o !== RW'(nv / C)) begin
            terr++;
         end
      end
      enc_valid_i = 1'b0;
      chk("run_finished", fin, 1);
      tick();
      if (done_o) dones++;
      chk("run_idle_busy", busy_o, 0);
      chk("run_row_cnt_hold", row_cnt_o, rows);
   endtask

   initial begin
      int enc_cyc;
      int dones;
      int terr;
      int rows;

      rst_ni = 1'b0;
      load_start_i = 1'b0; thr_valid_i = 1'b0; thr_data_i = '0;
      start_i = 1'b0; rows_i = '0; abort_i = 1'b0; enc_valid_i = 1'b0;
      #12;
      chk("rst_loaded", loaded_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_encoder", encoder_o, 0);
      chk("rst_ready", thr_ready_o, 0);
      chk("rst_we", we_o, 0);
      chk("rst_waddr", waddr_o, 0);
      chk("rst_wdata", wdata_o[31:0], 0);
      chk("rst_row_cnt", row_cnt_o, 0);
      #10;
      rst_ni = 1'b1;
      tick();

      // start before any load is ignored
      start_i = 1'b1; rows_i = 16'd2;
      tick();
      start_i = 1'b0;
      chk("noload_busy", busy_o, 0);
      chk("noload_encoder", encoder_o, 0);
      tick();
      chk("noload_encoder2", encoder_o, 0);

      // full load, data = word index
      clear_dut_mem();
      do_load(NW, 1'b0, 1'b0);
      chk("load_mem_diffs", mem_diffs(), 0);
      chk("load_u0_a0", dut_mem[0][0], 0);
      chk("load_u0_a127", dut_mem[0][127], 127);
      chk("load_u3_a127", dut_mem[3][127], 511);
      chk("load_nwrites", nwrites, NW);
      chk("load_spurious_we", spurious, 0);
      chk("load_loaded", loaded_o, 1);
      chk("load_ready_low", thr_ready_o, 0);
      chk("load_busy_low", busy_o, 0);

      // two rows, result every cycle
      do_run(2, 100, enc_cyc, dones, terr);
      chk("run2_enc_cycles", enc_cyc, 64);
      chk("run2_done_pulses", dones, 1);
      chk("run2_trace_err", terr, 0);
      chk("run2_loaded", loaded_o, 1);

      // zero rows: straight to DONE
      start_i = 1'b1; rows_i = 16'd0;
      tick();
      start_i = 1'b0;
      chk("rows0_done", done_o, 1);
      chk("rows0_encoder", encoder_o, 0);
      chk("rows0_row_cnt", row_cnt_o, 0);
      enc_valid_i = 1'b1;
      tick();
      chk("rows0_done_gone", done_o, 0);
      chk("rows0_encoder2", encoder_o, 0);
      tick();
      enc_valid_i = 1'b0;
      chk("idle_enc_valid_ignored", row_cnt_o, 0);

      // load_start and start together: load wins
      load_start_i = 1'b1; start_i = 1'b1; rows_i = 16'd2;
      tick();
      load_start_i = 1'b0; start_i = 1'b0;
      chk("both_ready", thr_ready_o, 1);
      chk("both_encoder", encoder_o, 0);
      chk("both_loaded_cleared", loaded_o, 0);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      chk("both_abort_busy", busy_o, 0);

      // abort after word 200 of a load
      do_load(201, 1'b1, 1'b0);
      chk("ab_load_spurious_we", spurious, 0);
      abort_i = 1'b1; thr_valid_i = 1'b1;
      tick();
      abort_i = 1'b0; thr_valid_i = 1'b0;
      chk("ab_load_loaded", loaded_o, 0);
      chk("ab_load_busy", busy_o, 0);
      chk("ab_load_ready", thr_ready_o, 0);
      chk("ab_load_we", we_o, 0);
      start_i = 1'b1; rows_i = 16'd1;
      tick();
      start_i = 1'b0;
      chk("ab_load_start_ignored", encoder_o, 0);

      // load with valid low every other cycle, random data
      clear_dut_mem();
      do_load(NW, 1'b1, 1'b1);
      chk("gap_mem_diffs", mem_diffs(), 0);
      chk("gap_nwrites", nwrites, NW);
      chk("gap_spurious_we", spurious, 0);
      chk("gap_loaded", loaded_o, 1);

      // random row count and random result valid pattern
      rows = $urandom_range(3, 1);
      do_run(rows, 60, enc_cyc, dones, terr);
      chk("rnd_done_pulses", dones, 1);
      chk("rnd_trace_err", terr, 0);

      // abort mid-run
      start_i = 1'b1; rows_i = 16'd3;
      tick();
      start_i = 1'b0;
      enc_valid_i = 1'b1;
      repeat (40) tick();
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0; enc_valid_i = 1'b0;
      chk("ab_run_encoder", encoder_o, 0);
      chk("ab_run_busy", busy_o, 0);
      chk("ab_run_done", done_o, 0);
      chk("ab_run_row_cnt", row_cnt_o, 1);
      tick();
      chk("ab_run_done2", done_o, 0);
      chk("ab_run_loaded", loaded_o, 1);

      // reset mid-run
      start_i = 1'b1; rows_i = 16'd3;
      tick();
      start_i = 1'b0;
      enc_valid_i = 1'b1;
      repeat (10) tick();
      chk("pre_rst_encoder", encoder_o, 1);
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_encoder", encoder_o, 0);
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_loaded", loaded_o, 0);
      chk("mid_rst_row_cnt", row_cnt_o, 0);
      #2;
      rst_ni = 1'b1;
      enc_valid_i = 1'b0;
      start_i = 1'b1; rows_i = 16'd2;
      tick();
      start_i = 1'b0;
      chk("post_rst_start_busy", busy_o, 0);
      chk("post_rst_start_encoder", encoder_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
